pipe_skid_reg: RTL and testbench

//  Two-entry valid/ready pipeline register for the softcore's inter-stage paths.
//  A plain stage register loads on every clock; this block is the consuming end of that path.
//  It carries producer data to the consumer and absorbs consumer back-pressure without data loss.
//  in_ready is fully registered, so out_ready has no combinational path to in_ready.

---
 rtl/pipe_skid_reg_if.sv | 42 ++++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg_if
// Description : Valid/ready handshake bundle for the pipe_skid_reg stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  // The slave side is the skid register itself; the master side is its environment.
  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output count
  );

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry valid/ready pipeline register with a registered
//               in_ready, so back-pressure never forms a combinational path.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input wire             clk,
  input wire             reset,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic             w_main_from_skid;
  logic             w_skid_ld;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = (r_state != S_EMPTY) & bus.out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    // Flush wins over any fire; a coincident in_fire is deliberately dropped.
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_main_ld   = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_ld = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_skid_ld   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = S_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Data registers are untouched by flush; out_valid qualifies out_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_ld) begin
        r_main <= bus.in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.out_data  = r_main;
  assign bus.count     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Directed self-checking bench for pipe_skid_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

  localparam int c_width = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipe_skid_reg_if #(.WIDTH(c_width)) bus ();

  pipe_skid_reg #(.WIDTH(c_width)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_A5A5;
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    n_checks++; if (bus.count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got=%b exp=0", bus.out_valid); end
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL first_edge_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.count !== 2'd0) begin n_fail++; $display("FAIL first_edge_count got=%0d exp=0", bus.count); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL accept_out_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL accept_out_data got=%h exp=a5a5a5a5", bus.out_data); end
    n_checks++; if (bus.count !== 2'd1) begin n_fail++; $display("FAIL accept_count got=%0d exp=1", bus.count); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.count !== 2'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'(i);
      tick();
      n_checks++; if (bus.out_data !== 32'(i) || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_data[%0d] got=%h v=%b exp=%h v=1", i, bus.out_data, bus.out_valid, i); end
      n_checks++; if (bus.count !== 2'd1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_state[%0d] count=%0d rdy=%b exp count=1 rdy=1", i, bus.count, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain count=%0d v=%b exp 0/0", bus.count, bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h10;
    tick();
    bus.in_data = 32'h11;
    tick();
    n_checks++; if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full count=%0d rdy=%b exp 2/0", bus.count, bus.in_ready); end
    bus.in_data = 32'h12;
    tick();
    n_checks++; if (bus.count !== 2'd2 || bus.out_data !== 32'h10) begin n_fail++; $display("FAIL bp_hold count=%0d data=%h exp 2/10", bus.count, bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_data !== 32'h11 || bus.count !== 2'd1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second data=%h count=%0d rdy=%b exp 11/1/1", bus.out_data, bus.count, bus.in_ready); end
    tick();
    n_checks++; if (bus.out_data !== 32'h12 || bus.count !== 2'd1) begin n_fail++; $display("FAIL bp_third data=%h count=%0d exp 12/1", bus.out_data, bus.count); end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain count=%0d v=%b exp 0/0", bus.count, bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h20;
    tick();
    bus.in_data = 32'h21;
    tick();
    n_checks++; if (bus.count !== 2'd2) begin n_fail++; $display("FAIL flush_prefill count=%0d exp=2", bus.count); end
    bus.in_valid = 1'b0; bus.flush = 1'b1; bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty count=%0d v=%b rdy=%b exp 0/0/1", bus.count, bus.out_valid, bus.in_ready); end
    bus.flush = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin n_fail++; $display("FAIL flush_no_resurrect v=%b count=%0d exp 0/0", bus.out_valid, bus.count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h2F;
    tick();
    n_checks++; if (bus.count !== 2'd1 || bus.out_data !== 32'h2F) begin n_fail++; $display("FAIL sim_prefill count=%0d data=%h exp 1/2f", bus.count, bus.out_data); end
    bus.in_data = 32'h30; bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.count !== 2'd1 || bus.out_data !== 32'h30 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sim_swap count=%0d data=%h v=%b exp 1/30/1", bus.count, bus.out_data, bus.out_valid); end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h40;
    tick();
    bus.in_data = 32'h41;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.count !== 2'd2 || bus.out_data !== 32'h40) begin n_fail++; $display("FAIL ar_prefill count=%0d data=%h exp 2/40", bus.count, bus.out_data); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin n_fail++; $display("FAIL ar_state v=%b count=%0d exp 0/0", bus.out_valid, bus.count); end
    n_checks++; if (bus.out_data !== 32'h0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ar_outputs data=%h rdy=%b exp 0/0", bus.out_data, bus.in_ready); end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
